instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 36 +++
 rtl/instr_fetch.sv | 107 ++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, redirect request and decode-side handshake.
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    input  if_ready,
    output if_valid,
    output if_pc,
    output if_instr,
    output if_fault
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    output if_ready,
    input  if_valid,
    input  if_pc,
    input  if_instr,
    input  if_fault
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, one-entry output buffer with ready/valid, redirects.
// Optional fetch address range check is enabled by defining FETCH_BOUND_CHECK_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  localparam logic [31:0] Nop            = 32'h0000_0013;
  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] word_idx;
  logic [31:0] redirect_aligned;
  logic        out_of_range;

  assign word_idx         = {2'b00, pc_q[31:2]};
  assign redirect_aligned = {bus.redirect_pc[31:2], 2'b00};

`ifdef FETCH_BOUND_CHECK_EN
  assign out_of_range = (word_idx >= IMEM_DEPTH);
`else
  assign out_of_range = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    valid_d    = valid_q;
    fault_d    = fault_q;

    if (bus.redirect_valid && (state_q != StBoot)) begin
      // Redirect beats both fetch and stall; the buffered output is dropped.
      pc_d    = redirect_aligned;
      valid_d = 1'b0;
      fault_d = 1'b0;
      state_d = StRun;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_d = StRun;
          if (bus.redirect_valid) begin
            pc_d = redirect_aligned;
          end
        end
        StRun: begin
          if (!valid_q || bus.if_ready) begin
            if_pc_d = pc_q;
            valid_d = 1'b1;
            if (out_of_range) begin
              if_instr_d = Nop;
              fault_d    = 1'b1;
              state_d    = StHalt;
            end else begin
              if_instr_d = bus.imem_instr;
              fault_d    = 1'b0;
              pc_d       = pc_q + 32'd4;
            end
          end
        end
        StHalt: begin
          if (bus.if_ready) begin
            valid_d = 1'b0;
          end
        end
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= ResetPcAligned;
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= Nop;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.imem_addr = word_idx;
  assign bus.if_valid  = valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_fault  = fault_q;

endmodule
